// File: rtl/control_unit.sv
// Multi-cycle controller for a small 8-bit CPU: fetches a 3-byte instruction
// (opcode, operando1, operando2), decodes it and sequences the datapath,
// including a RAM access phase for LOAD/STORE and a sticky HALT state.
module control_unit #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pc,
  input  logic [7:0] opcode,
  input  logic [7:0] operando1,
  input  logic [7:0] operando2,
  input  logic       mem_ready,
  input  logic       alu_zero,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic       ir_load_op,
  output logic       ir_load_a,
  output logic       ir_load_b,
  output logic       pc_inc,
  output logic       pc_load,
  output logic [7:0] pc_load_val,
  output logic       rf_we,
  output logic       rf_wsel,
  output logic [2:0] rf_addr_a,
  output logic [2:0] rf_addr_b,
  output logic [1:0] alu_op,
  output logic       halted,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StFetch0 = 3'd0,
    StFetch1 = 3'd1,
    StFetch2 = 3'd2,
    StDecode = 3'd3,
    StExec   = 3'd4,
    StMemAcc = 3'd5,
    StHalt   = 3'd6
  } state_t;

  localparam logic [7:0] OpNop   = 8'h00;
  localparam logic [7:0] OpLoad  = 8'h01;
  localparam logic [7:0] OpStore = 8'h02;
  localparam logic [7:0] OpAdd   = 8'h03;
  localparam logic [7:0] OpSub   = 8'h04;
  localparam logic [7:0] OpJmp   = 8'h05;
  localparam logic [7:0] OpJz    = 8'h06;
  localparam logic [7:0] OpHlt   = 8'hFF;

  state_t state_q, state_d;
  logic   z_q, z_d;
  logic   illegal_q, illegal_d;

  // Only the low three bits of the operands address the register file.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{operando1[7:3]};

  // State, zero flag and illegal flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch0;
      z_q       <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      z_q       <= z_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and output decode; reset overrides everything combinationally so
  // an in-flight access is dropped immediately and the PC is forced to PC_RESET.
  always_comb begin
    state_d     = state_q;
    z_d         = z_q;
    illegal_d   = illegal_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 8'h00;
    ir_load_op  = 1'b0;
    ir_load_a   = 1'b0;
    ir_load_b   = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = 8'h00;
    rf_we       = 1'b0;
    rf_wsel     = 1'b0;
    rf_addr_a   = 3'd0;
    rf_addr_b   = 3'd0;
    alu_op      = 2'b00;

    if (reset) begin
      pc_load     = 1'b1;
      pc_load_val = PC_RESET;
    end else begin
      unique case (state_q)
        StFetch0, StFetch1, StFetch2: begin
          mem_req  = 1'b1;
          mem_addr = pc;
          if (mem_ready) begin
            pc_inc = 1'b1;
            unique case (state_q)
              StFetch0: begin ir_load_op = 1'b1; state_d = StFetch1; end
              StFetch1: begin ir_load_a  = 1'b1; state_d = StFetch2; end
              default:  begin ir_load_b  = 1'b1; state_d = StDecode; end
            endcase
          end
        end
        StDecode: begin
          rf_addr_a = operando1[2:0];
          rf_addr_b = operando2[2:0];
          state_d   = StExec;
        end
        StExec: begin
          rf_addr_a = operando1[2:0];
          rf_addr_b = operando2[2:0];
          state_d   = StFetch0;
          case (opcode)
            OpNop: ;
            OpAdd, OpSub: begin
              rf_we  = 1'b1;
              alu_op = (opcode == OpSub) ? 2'b01 : 2'b00;
              z_d    = alu_zero;
            end
            OpJmp: begin
              pc_load     = 1'b1;
              pc_load_val = operando2;
            end
            OpJz: begin
              pc_load     = z_q;
              pc_load_val = operando2;
            end
            OpLoad, OpStore: state_d = StMemAcc;
            OpHlt:           state_d = StHalt;
            default: begin
              illegal_d = 1'b1;
              state_d   = StHalt;
            end
          endcase
        end
        StMemAcc: begin
          rf_addr_a = operando1[2:0];
          rf_addr_b = operando2[2:0];
          mem_req   = 1'b1;
          mem_addr  = operando2;
          mem_we    = (opcode == OpStore);
          if (mem_ready) begin
            if (opcode == OpLoad) begin
              rf_we   = 1'b1;
              rf_wsel = 1'b1;
            end
            state_d = StFetch0;
          end
        end
        StHalt: ;
        default: state_d = StFetch0;
      endcase
    end
  end

  // Status outputs read as their reset values while reset is held.
  assign halted  = !reset && (state_q == StHalt);
  assign illegal = !reset && illegal_q;
  assign state   = reset ? StFetch0 : state_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: surrounds the controller with a small
// PC/IR/RAM environment, runs a directed instruction table and a random
// instruction stream checked against an instruction-level reference model.
module tb_control_unit;

  localparam logic [7:0] PcReset = 8'h10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pc_r = 8'h00;
  logic [7:0] opcode = 8'h00, operando1 = 8'h00, operando2 = 8'h00;
  logic       mem_ready = 1'b0, alu_zero = 1'b0;
  logic       mem_req, mem_we, ir_load_op, ir_load_a, ir_load_b, pc_inc, pc_load;
  logic       rf_we, rf_wsel, halted, illegal;
  logic [7:0] mem_addr, pc_load_val;
  logic [2:0] rf_addr_a, rf_addr_b, state;
  logic [1:0] alu_op;

  control_unit #(.PC_RESET(PcReset)) dut (
    .clk(clk), .reset(reset), .pc(pc_r), .opcode(opcode), .operando1(operando1),
    .operando2(operando2), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .ir_load_op(ir_load_op),
    .ir_load_a(ir_load_a), .ir_load_b(ir_load_b), .pc_inc(pc_inc), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_addr_a(rf_addr_a),
    .rf_addr_b(rf_addr_b), .alu_op(alu_op), .halted(halted), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rf_n; int rf_cyc; int rf_addr; int rf_wsel; int alu_op;
    int pl_n; int pl_val; int wr_n; int wr_addr; int ld_addr;
    int end_st; int ill; int pc_after;
  } res_t;

  typedef struct {
    logic [7:0] op; logic [7:0] a; logic [7:0] b; int d; logic z; res_t exp;
  } vec_t;

  logic [7:0] mem [256];
  int   n_err = 0, n_chk = 0;
  int   wait_cnt = 0, cur_delay = 0, cyc_idx = 0, viol = 0;
  logic cur_zero = 1'b0;
  logic after_reset = 1'b0;
  logic [7:0] cur_pc;
  logic ref_z;
  res_t o;
  int   n_irop, n_ira, n_irb, n_pcinc, o_rfb, req_cycles, strobe_cycles;
  logic first_req;
  logic [7:0] first_addr;
  // Snapshot of the sampled outputs, applied to the environment after the edge.
  logic t_req, t_rdy, t_we, t_irop, t_ira, t_irb, t_inc, t_pl, t_rfwe;
  logic [7:0] t_addr, t_plv;
  logic [2:0] t_state;
  logic t_halted, t_illegal;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, sample outputs mid-cycle, then update PC/IR/RAM.
  task automatic cycle();
    int nir;
    @(negedge clk);
    mem_ready = (wait_cnt >= cur_delay);
    alu_zero  = cur_zero;
    #1;
    cyc_idx++;
    if (!reset) begin
      if (ir_load_op) n_irop++;
      if (ir_load_a) n_ira++;
      if (ir_load_b) n_irb++;
      if (pc_inc) n_pcinc++;
      if (rf_we) begin
        o.rf_n++; o.rf_cyc = cyc_idx; o.rf_addr = int'(rf_addr_a);
        o.rf_wsel = int'(rf_wsel); o.alu_op = int'(alu_op); o_rfb = int'(rf_addr_b);
        if (rf_wsel && mem_req && mem_ready) o.ld_addr = int'(mem_addr);
      end
      if (pc_load) begin o.pl_n++; o.pl_val = int'(pc_load_val); end
      if (mem_req && mem_we && mem_ready) begin o.wr_n++; o.wr_addr = int'(mem_addr); end
      if (mem_req) req_cycles++;
      if (ir_load_op || ir_load_a || ir_load_b || pc_inc || pc_load || rf_we)
        strobe_cycles++;
      nir = int'(ir_load_op) + int'(ir_load_a) + int'(ir_load_b);
      if (nir > 1 || (pc_inc != (nir == 1)) || (nir + int'(pc_load) + int'(rf_we) > 1))
        viol++;
      if (cyc_idx == 1) begin first_req = mem_req; first_addr = mem_addr; end
    end
    t_req = mem_req; t_rdy = mem_ready; t_we = mem_we; t_addr = mem_addr;
    t_irop = ir_load_op; t_ira = ir_load_a; t_irb = ir_load_b; t_inc = pc_inc;
    t_pl = pc_load; t_plv = pc_load_val; t_rfwe = rf_we;
    t_state = state; t_halted = halted; t_illegal = illegal;
    @(posedge clk);
    #1;
    if (t_pl) pc_r = t_plv;
    else if (t_inc) pc_r = pc_r + 8'd1;
    if (t_irop) opcode = mem[t_addr];
    if (t_ira) operando1 = mem[t_addr];
    if (t_irb) operando2 = mem[t_addr];
    wait_cnt = t_req ? (t_rdy ? 0 : wait_cnt + 1) : 0;
  endtask

  task automatic clear_obs();
    o = '{default: 0};
    n_irop = 0; n_ira = 0; n_irb = 0; n_pcinc = 0; o_rfb = 0;
    req_cycles = 0; strobe_cycles = 0; cyc_idx = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cur_delay = 0;
    cycle();
    chk("rst_mem_req", int'(t_req), 0);
    chk("rst_pc_load", int'(t_pl), 1);
    chk("rst_pc_load_val", int'(t_plv), int'(PcReset));
    chk("rst_strobes", int'({t_irop, t_ira, t_irb, t_inc, t_rfwe}), 0);
    chk("rst_status", int'({t_state, t_halted, t_illegal}), 0);
    cycle();
    chk("rst_state_held", int'(t_state), 0);
    reset = 1'b0;
    after_reset = 1'b1;
    cur_pc = PcReset;
    ref_z = 1'b0;
  endtask

  // Instruction-level reference: what one instruction must do to the outside world.
  function automatic res_t model(input logic [7:0] op, a, b, pc, input int d, input logic z);
    res_t r = '{default: 0};
    r.pc_after = int'(8'(pc + 8'd3));
    case (op)
      8'h00: ;
      8'h01: begin
        r.rf_n = 1; r.rf_cyc = 4 * d + 6; r.rf_addr = int'(a[2:0]);
        r.rf_wsel = 1; r.ld_addr = int'(b);
      end
      8'h02: begin r.wr_n = 1; r.wr_addr = int'(b); end
      8'h03, 8'h04: begin
        r.rf_n = 1; r.rf_cyc = 3 * d + 5; r.rf_addr = int'(a[2:0]);
        r.alu_op = (op == 8'h04) ? 1 : 0;
      end
      8'h05: begin r.pl_n = 1; r.pl_val = int'(b); r.pc_after = int'(b); end
      8'h06: if (z) begin r.pl_n = 1; r.pl_val = int'(b); r.pc_after = int'(b); end
      8'hFF: r.end_st = 6;
      default: begin r.end_st = 6; r.ill = 1; end
    endcase
    return r;
  endfunction

  // Place one instruction at cur_pc, run it for its expected cycle count and check.
  task automatic run_instr(input logic [7:0] op, a, b, input int d, input logic zv,
                           input res_t exp, input int stop_at);
    int ncyc;
    cur_delay = d;
    cur_zero  = zv;
    mem[cur_pc] = op;
    mem[8'(cur_pc + 8'd1)] = a;
    mem[8'(cur_pc + 8'd2)] = b;
    ncyc = 3 * (d + 1) + 2 + ((op == 8'h01 || op == 8'h02) ? d + 1 : 0);
    if (stop_at > 0) ncyc = stop_at;
    clear_obs();
    repeat (ncyc) cycle();
    if (stop_at > 0) return;
    if (after_reset) begin
      chk("first_fetch_req", int'(first_req), 1);
      chk("first_fetch_addr", int'(first_addr), int'(PcReset));
      after_reset = 1'b0;
    end
    chk("ir_load_op_n", n_irop, 1);
    chk("ir_load_a_n", n_ira, 1);
    chk("ir_load_b_n", n_irb, 1);
    chk("pc_inc_n", n_pcinc, 3);
    chk("rf_we_n", o.rf_n, exp.rf_n);
    chk("rf_we_cycle", o.rf_cyc, exp.rf_cyc);
    chk("rf_addr_a", o.rf_addr, exp.rf_addr);
    chk("rf_addr_b", o_rfb, (exp.rf_n != 0) ? int'(b[2:0]) : 0);
    chk("rf_wsel", o.rf_wsel, exp.rf_wsel);
    chk("alu_op", o.alu_op, exp.alu_op);
    chk("pc_load_n", o.pl_n, exp.pl_n);
    chk("pc_load_val", o.pl_val, exp.pl_val);
    chk("store_n", o.wr_n, exp.wr_n);
    chk("store_addr", o.wr_addr, exp.wr_addr);
    chk("load_addr", o.ld_addr, exp.ld_addr);
    #1;
    chk("end_state", int'(state), exp.end_st);
    chk("halted", int'(halted), (exp.end_st == 6) ? 1 : 0);
    chk("illegal", int'(illegal), exp.ill);
    chk("pc_after", int'(pc_r), exp.pc_after);
    cur_pc = 8'(exp.pc_after);
  endtask

  // Once halted, nothing may happen even with mem_ready held high.
  task automatic halt_check(input logic exp_ill);
    cur_delay = 0;
    clear_obs();
    repeat (5) cycle();
    chk("halt_mem_req", req_cycles, 0);
    chk("halt_strobes", strobe_cycles, 0);
    chk("halt_sticky", int'({t_halted, t_illegal}), int'({1'b1, exp_ill}));
  endtask

  vec_t tbl [10];
  res_t dummy;

  initial begin
    dummy = '{default: 0};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    //            op     a      b      d  z     rf cyc ad ws al pl val  wr wa  ld  st il pc
    tbl[0] = '{8'h03, 8'h01, 8'h02, 0, 1'b0, '{1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h13}};
    tbl[1] = '{8'h04, 8'h03, 8'h07, 1, 1'b1, '{1, 8, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 'h16}};
    tbl[2] = '{8'h06, 8'h00, 8'h40, 0, 1'b0, '{0, 0, 0, 0, 0, 1, 'h40, 0, 0, 0, 0, 0, 'h40}};
    tbl[3] = '{8'h03, 8'h02, 8'h05, 0, 1'b0, '{1, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h43}};
    tbl[4] = '{8'h06, 8'h00, 8'h40, 0, 1'b1, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h46}};
    tbl[5] = '{8'h01, 8'h05, 8'h20, 3, 1'b0, '{1, 18, 5, 1, 0, 0, 0, 0, 0, 'h20, 0, 0, 'h49}};
    tbl[6] = '{8'h05, 8'h00, 8'hFE, 0, 1'b0, '{0, 0, 0, 0, 0, 1, 'hFE, 0, 0, 0, 0, 0, 'hFE}};
    tbl[7] = '{8'h00, 8'h00, 8'h00, 0, 1'b0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h01}};
    tbl[8] = '{8'h02, 8'h04, 8'h33, 2, 1'b0, '{0, 0, 0, 0, 0, 0, 0, 1, 'h33, 0, 0, 0, 'h04}};
    tbl[9] = '{8'h7A, 8'h00, 8'h00, 0, 1'b0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 1, 'h07}};

    do_reset();
    for (int i = 0; i < 10; i++)
      run_instr(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].z, tbl[i].exp, 0);
    halt_check(1'b1);

    // Reset during the wait phase of a STORE must abort it without a write.
    do_reset();
    run_instr(8'h02, 8'h01, 8'h33, 3, 1'b0, dummy, 15);
    chk("abort_in_memacc", int'(t_state), 5);
    do_reset();
    chk("abort_no_write", o.wr_n, 0);
    run_instr(8'h03, 8'h06, 8'h01, 1, 1'b0, model(8'h03, 8'h06, 8'h01, cur_pc, 1, 1'b0), 0);
    ref_z = 1'b0;

    // Random instruction stream against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic [7:0] op, a, b;
      int   k, d;
      logic zv;
      res_t e;
      k  = int'($urandom_range(0, 31));
      if (k < 28) op = 8'(k % 7);
      else if (k < 30) op = 8'hFF;
      else op = 8'(8'h07 + $urandom_range(0, 247));
      a  = 8'($urandom);
      b  = 8'($urandom);
      d  = int'($urandom_range(0, 3));
      zv = 1'($urandom);
      e  = model(op, a, b, cur_pc, d, ref_z);
      run_instr(op, a, b, d, zv, e, 0);
      if (op == 8'h03 || op == 8'h04) ref_z = zv;
      if (e.end_st == 6) begin
        halt_check(e.ill != 0);
        do_reset();
      end
    end

    chk("strobe_overlap", viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter PC_RESET, default 8'h00, value driven on pc_load_val while reset is high.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port pc  input  8  current value from the program counter.
REQ-005 SHALL have ports opcode, operando1, operando2  input  8 each  instruction register bytes.
REQ-006 SHALL have port mem_ready  input  1  RAM access complete this cycle.
REQ-007 SHALL have port alu_zero  input  1  ALU result-is-zero flag, valid in the EXEC cycle.
REQ-008 SHALL have ports mem_req, mem_we  output  1 each  RAM request and write-enable.
REQ-009 SHALL have port mem_addr  output  8  RAM/MAR address.
REQ-010 SHALL have ports ir_load_op, ir_load_a, ir_load_b  output  1 each  load opcode/operando1/operando2 from RAM data.
REQ-011 SHALL have ports pc_inc, pc_load  output  1 each, and pc_load_val  output  8.
REQ-012 SHALL have ports rf_we  output  1, rf_wsel  output  1 (0=ALU, 1=RAM), rf_addr_a, rf_addr_b  output  3 each.
REQ-013 SHALL have ports alu_op  output  2 (00 ADD, 01 SUB), halted  output  1, illegal  output  1, state  output  3 (debug).

Function
REQ-014 SHALL implement states FETCH0=0, FETCH1=1, FETCH2=2, DECODE=3, EXEC=4, MEMACC=5, HALT=6.
REQ-015 FETCHn: mem_req=1, mem_we=0, mem_addr=pc, held until mem_ready=1.
REQ-016 On the mem_ready cycle in FETCH0/1/2: assert ir_load_op/ir_load_a/ir_load_b respectively plus pc_inc, exactly one cycle, then advance to the next state.
REQ-017 DECODE: one cycle, no outputs asserted, then EXEC.
REQ-018 Opcode map: 00 NOP, 01 LOAD, 02 STORE, 03 ADD, 04 SUB, 05 JMP, 06 JZ, FF HLT; any other value is illegal.
REQ-019 rf_addr_a=operando1[2:0], rf_addr_b=operando2[2:0] in DECODE, EXEC and MEMACC; 0 otherwise.
REQ-020 EXEC for ADD/SUB: rf_we=1, rf_wsel=0, alu_op per map, latch alu_zero into internal Z, next FETCH0.
REQ-021 EXEC for NOP: no outputs, next FETCH0.
REQ-022 EXEC for JMP: pc_load=1, pc_load_val=operando2, next FETCH0.
REQ-023 EXEC for JZ: pc_load=Z, pc_load_val=operando2, next FETCH0.
REQ-024 EXEC for LOAD/STORE: next MEMACC; MEMACC drives mem_req=1, mem_addr=operando2, mem_we=1 for STORE only.
REQ-025 MEMACC holds until mem_ready; on that cycle LOAD asserts rf_we=1, rf_wsel=1 (write register operando1[2:0]); then FETCH0.
REQ-026 EXEC for HLT: next HALT; EXEC for illegal opcode: set illegal=1, next HALT.
REQ-027 HALT: halted=1, all strobes 0, sticky until reset.
REQ-028 All strobes (ir_load_*, pc_inc, pc_load, rf_we) SHALL be single-cycle pulses, never simultaneous with each other except pc_inc with ir_load_*.
REQ-029 pc wrap from FF to 00 SHALL be transparent: the controller fetches at pc as presented.
REQ-030 mem_ready outside FETCHn/MEMACC SHALL be ignored.

Reset
REQ-031 While reset is high: state=FETCH0, Z=0, illegal=0, halted=0, mem_req=0, all strobes 0, pc_load=1, pc_load_val=PC_RESET.
REQ-032 Reset asserted mid-fetch or mid-MEMACC SHALL abort the access; mem_req=0 from the cycle after reset is sampled; no rf_we or ir_load pulse is issued.
REQ-033 First fetch SHALL start the cycle after reset deasserts.

Verification
REQ-034 Program ADD (03 01 02), mem_ready tied 1 -> three ir_load pulses, pc +3, rf_we at cycle 5 after fetch start, back to FETCH0 at cycle 6.
REQ-035 LOAD 01 05 20 with mem_ready delayed 3 cycles per access -> mem_req held, mem_addr=20 in MEMACC, rf_we with rf_wsel=1 once.
REQ-036 SUB giving alu_zero=1 then JZ 06 00 40 -> pc_load=1, pc_load_val=40; repeat with alu_zero=0 -> no pc_load.
REQ-037 Opcode 7A -> illegal=1, halted=1, no further mem_req until reset.
REQ-038 Reset pulsed during MEMACC of STORE -> mem_req drops next cycle, state=FETCH0, pc_load_val=PC_RESET.
